btb: RTL and testbench

Branch target buffer in the fetch stage, directly upstream of the 2-bit branch predictor. It is indexed by the fetch PC and supplies a registered hit flag and predicted target one cycle later, alongside the instruction entering decode. The predictor combines the hit flag with its taken/not-taken counter to form the redirect PC. The BTB is trained from resolved branches in execute; allocation and eviction are controlled by a per-entry 1-bit confidence flag.

---
 rtl/btb.sv | 138 +++++++++++++
 tb/tb_btb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/btb.sv
// Direct-mapped branch target buffer: registered lookup, trained by resolved branches
// using a 1-bit confidence flag per entry. Define BTB_BYPASS_EN to forward same-index updates.
module btb #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        clr,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic [31:0] target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [N-1:0]     valid_q;
  logic [N-1:0]     conf_q;
  logic [TAG_W-1:0] tag_q [N];
  logic [31:0]      tgt_q [N];

  logic [IDX_W-1:0] u_idx_s;
  logic [TAG_W-1:0] u_tag_s;
  logic             u_hit_s;
  logic             n_valid_s;
  logic             n_conf_s;
  logic [TAG_W-1:0] n_tag_s;
  logic [31:0]      n_tgt_s;

  logic [IDX_W-1:0] l_idx_s;
  logic [TAG_W-1:0] l_tag_s;
  logic             r_valid_s;
  logic [TAG_W-1:0] r_tag_s;
  logic [31:0]      r_tgt_s;
  logic             match_s;

  logic             hit_q, hit_d;
  logic [31:0]      target_q, target_d;

  assign u_idx_s = upd_pc[IDX_W+1:2];
  assign u_tag_s = upd_pc[31:IDX_W+2];
  assign l_idx_s = lookup_pc[IDX_W+1:2];
  assign l_tag_s = lookup_pc[31:IDX_W+2];
  assign u_hit_s = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);

  // Post-update contents of the entry addressed by the update port
  always_comb begin
    n_valid_s = valid_q[u_idx_s];
    n_conf_s  = conf_q[u_idx_s];
    n_tag_s   = tag_q[u_idx_s];
    n_tgt_s   = tgt_q[u_idx_s];
    if (upd_taken) begin
      // Taken hit and taken miss collapse: both (re)write the whole entry with conf set.
      n_valid_s = 1'b1;
      n_conf_s  = 1'b1;
      n_tag_s   = u_tag_s;
      n_tgt_s   = upd_target;
    end else if (u_hit_s) begin
      if (conf_q[u_idx_s]) begin
        n_conf_s = 1'b0;
      end else begin
        n_valid_s = 1'b0;
      end
    end else begin
      n_valid_s = valid_q[u_idx_s];
    end
  end

  // Table storage; reset clears every entry and drops a coincident update
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      conf_q  <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= 32'h0;
      end
    end else if (upd_en) begin
      valid_q[u_idx_s] <= n_valid_s;
      conf_q[u_idx_s]  <= n_conf_s;
      tag_q[u_idx_s]   <= n_tag_s;
      tgt_q[u_idx_s]   <= n_tgt_s;
    end
  end

  // Entry seen by the lookup port, optionally forwarded from a same-index update
  always_comb begin
    r_valid_s = valid_q[l_idx_s];
    r_tag_s   = tag_q[l_idx_s];
    r_tgt_s   = tgt_q[l_idx_s];
`ifdef BTB_BYPASS_EN
    if (upd_en && (u_idx_s == l_idx_s)) begin
      r_valid_s = n_valid_s;
      r_tag_s   = n_tag_s;
      r_tgt_s   = n_tgt_s;
    end else begin
      r_valid_s = valid_q[l_idx_s];
    end
`endif
    match_s = r_valid_s && (r_tag_s == l_tag_s);
  end

  // Output register next state: clr > stall > capture
  always_comb begin
    hit_d    = hit_q;
    target_d = target_q;
    if (clr) begin
      hit_d    = 1'b0;
      target_d = 32'h0;
    end else if (stall) begin
      hit_d    = hit_q;
      target_d = target_q;
    end else begin
      hit_d    = match_s;
      target_d = match_s ? r_tgt_s : 32'h0;
    end
  end

  // Lookup output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q    <= 1'b0;
      target_q <= 32'h0;
    end else begin
      hit_q    <= hit_d;
      target_q <= target_d;
    end
  end

  assign hit    = hit_q;
  assign target = target_q;

endmodule

// File: tb/tb_btb.sv
// Randomized self-checking bench for btb against a table-level reference model.
module tb_btb;

  logic        clk = 1'b0;
  logic        reset, stall, clr, upd_en, upd_taken;
  logic [31:0] lookup_pc, upd_pc, upd_target;
  logic        hit;
  logic [31:0] target;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 16 entries addressed by word number mod 16, tag = pc / 64
  bit          m_valid [16];
  bit          m_conf  [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  bit          e_hit;
  int unsigned e_tgt;

  btb #(.IDX_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .clr(clr),
    .lookup_pc(lookup_pc), .hit(hit), .target(target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int unsigned m_index(input int unsigned pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned m_tagof(input int unsigned pc);
    return pc / 64;
  endfunction

  task automatic model_update();
    int unsigned i;
    bit present;
    i = m_index(upd_pc);
    present = m_valid[i] && (m_tag[i] == m_tagof(upd_pc));
    if (upd_taken) begin
      m_valid[i] = 1; m_conf[i] = 1; m_tag[i] = m_tagof(upd_pc); m_tgt[i] = upd_target;
    end else if (present && m_conf[i]) begin
      m_conf[i] = 0;
    end else if (present) begin
      m_valid[i] = 0;
    end
  endtask

  task automatic tick(input string tag);
    bit lh;
    int unsigned lt, i;
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0; m_conf[k] = 0; m_tag[k] = 0; m_tgt[k] = 0;
      end
      e_hit = 0; e_tgt = 0;
    end else begin
`ifdef BTB_BYPASS_EN
      if (upd_en) model_update();
`endif
      i  = m_index(lookup_pc);
      lh = m_valid[i] && (m_tag[i] == m_tagof(lookup_pc));
      lt = lh ? m_tgt[i] : 0;
`ifndef BTB_BYPASS_EN
      if (upd_en) model_update();
`endif
      if (clr) begin
        e_hit = 0; e_tgt = 0;
      end else if (!stall) begin
        e_hit = lh; e_tgt = lt;
      end
    end
    @(posedge clk);
    #1;
    check_eq({tag, ".hit"}, {31'h0, hit}, {31'h0, e_hit});
    check_eq({tag, ".target"}, target, e_tgt);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; clr = 1'b0; upd_en = 1'b0; upd_taken = 1'b0;
    upd_pc = 32'h0; upd_target = 32'h0; lookup_pc = 32'h0;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [31:0] tg, input logic tk);
    upd_en = 1'b1; upd_pc = pc; upd_target = tg; upd_taken = tk;
    lookup_pc = 32'h0000_0000;
    tick("upd");
    upd_en = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_pc = pc;
    tick("lkp");
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    tick("reset");
    check_eq("reset_hit", {31'h0, hit}, 32'h0);
    check_eq("reset_tgt", target, 32'h0);
    reset = 1'b0;

    do_lookup(32'h0040_0010);
    check_eq("empty_hit", {31'h0, hit}, 32'h0);
    for (int k = 0; k < 16; k++) do_lookup(32'h0040_0000 + 32'(k * 4));

    do_update(32'h0040_0010, 32'h0040_0100, 1'b1);
    do_lookup(32'h0040_0010);
    check_eq("alloc_hit", {31'h0, hit}, 32'h1);
    check_eq("alloc_tgt", target, 32'h0040_0100);

    do_update(32'h0040_0010, 32'h0, 1'b0);
    do_lookup(32'h0040_0010);
    check_eq("hyst1_hit", {31'h0, hit}, 32'h1);
    do_update(32'h0040_0010, 32'h0, 1'b0);
    do_lookup(32'h0040_0010);
    check_eq("hyst2_hit", {31'h0, hit}, 32'h0);

    do_update(32'h0040_0010, 32'h0040_0100, 1'b1);
    do_update(32'h0040_0050, 32'h0040_0200, 1'b1);
    do_lookup(32'h0040_0010);
    check_eq("alias_old", {31'h0, hit}, 32'h0);
    do_lookup(32'h0040_0050);
    check_eq("alias_hit", {31'h0, hit}, 32'h1);
    check_eq("alias_tgt", target, 32'h0040_0200);

    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lookup_pc = 32'h0040_0000 + 32'(k * 4);
      tick("stall");
      check_eq("stall_tgt", target, 32'h0040_0200);
    end
    stall = 1'b0;
    clr = 1'b1;
    tick("clr");
    check_eq("clr_hit", {31'h0, hit}, 32'h0);
    clr = 1'b0;
    do_lookup(32'h0040_0050);
    check_eq("post_clr", {31'h0, hit}, 32'h1);

    reset = 1'b1; tick("reset2"); reset = 1'b0;
    upd_en = 1'b1; upd_pc = 32'h0040_0010; upd_target = 32'h0040_0100; upd_taken = 1'b1;
    lookup_pc = 32'h0040_0010;
    tick("same");
`ifdef BTB_BYPASS_EN
    check_eq("same_cycle", {31'h0, hit}, 32'h1);
`else
    check_eq("same_cycle", {31'h0, hit}, 32'h0);
`endif
    reset = 1'b1;
    tick("rst_upd");
    reset = 1'b0; upd_en = 1'b0;
    do_lookup(32'h0040_0010);
    check_eq("rst_drop", {31'h0, hit}, 32'h0);

    for (int n = 0; n < 2000; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      clr        = ($urandom_range(0, 19) == 0);
      stall      = ($urandom_range(0, 7) == 0);
      upd_en     = ($urandom_range(0, 1) == 0);
      upd_taken  = ($urandom_range(0, 2) != 0);
      upd_pc     = 32'h0040_0000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      upd_target = $urandom;
      lookup_pc  = ($urandom_range(0, 2) == 0) ? upd_pc
                 : 32'h0040_0000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
